// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions.
//   XLEN_DEF : default address/PC width
//   ILEN     : instruction width
//   PC_INC   : sequential fetch stride in bytes
//   fetch_state_e : fetch controller states
package cpu_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned ILEN     = 32;
  localparam int unsigned PC_INC   = 4;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_RUN  = 2'd1,
    FS_STOP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction queue storage: DEPTH entries of WIDTH bits.
//   clk_i   : clock, rising edge
//   rst_i   : asynchronous active-low reset
//   push_i  : write data_i at the tail
//   data_i  : entry to write
//   pop_i   : retire the head entry
//   flush_i : empty the queue (wins over push/pop)
//   data_o  : head entry, zero when empty
//   count_o : number of valid entries
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter  int unsigned WIDTH = XLEN_DEF + ILEN,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  // Guards keep the pointers coherent even if a caller misbehaves.
  assign w_push = push_i && (r_count != CW'(DEPTH));
  assign w_pop  = pop_i  && (r_count != '0);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push && !flush_i) r_mem[r_wptr] <= data_i;
  end

  assign data_o  = (r_count != '0) ? r_mem[r_rptr] : '0;
  assign count_o = r_count;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch controller with a credit-limited prefetch queue.
//   clk_i, rst_i        : clock / asynchronous active-low reset
//   start_i             : fetching permitted while high
//   redirect_i          : one-cycle flush-and-jump strobe
//   redirect_pc_i       : jump target (low two bits ignored)
//   imem_req_o/addr_o   : memory request and address
//   imem_gnt_i          : request accepted this cycle
//   imem_rvalid_i/rdata_i : in-order memory response
//   instr_valid_o/instr_o/instr_pc_o : queue head
//   instr_ready_i       : consumer takes the head
//   busy_o              : requests in flight or queue non-empty
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEF,
  parameter int unsigned     DEPTH    = 4,
  parameter int unsigned     MAX_OUT  = 2,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [ILEN-1:0] imem_rdata_i,
  output logic            instr_valid_o,
  output logic [ILEN-1:0] instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  input  logic            instr_ready_i,
  output logic            busy_o
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned OW = $clog2(MAX_OUT + 1);
  localparam int unsigned SW = ((CW > OW) ? CW : OW) + 1;

  fetch_state_e         r_state;
  logic [XLEN-1:0]      r_fetch_pc;
  logic [XLEN-1:0]      r_rsp_pc;
  logic [OW-1:0]        r_out;
  logic [OW-1:0]        r_drop;

  logic [CW-1:0]        w_count;
  logic [SW-1:0]        w_used;
  logic [OW-1:0]        w_out_next;
  logic [XLEN-1:0]      w_redir_pc;
  logic [XLEN+ILEN-1:0] w_head;
  logic                 w_req;
  logic                 w_fire;
  logic                 w_rsp;
  logic                 w_drop;
  logic                 w_push;
  logic                 w_pop;

  // Queue slots plus in-flight requests may never exceed DEPTH, so every
  // response that comes back is guaranteed a slot.
  assign w_used = SW'(w_count) + SW'(r_out);
  assign w_req  = (r_state == FS_RUN) && start_i && !redirect_i &&
                  (r_out < OW'(MAX_OUT)) && (w_used < SW'(DEPTH));
  assign w_fire = w_req && imem_gnt_i;

  assign w_rsp  = imem_rvalid_i && (r_out != '0);
  assign w_drop = w_rsp && (r_drop != '0);
  // A response landing in the redirect cycle belongs to the old stream.
  assign w_push = w_rsp && !w_drop && !redirect_i;
  assign w_pop  = instr_valid_o && instr_ready_i;

  assign w_out_next = r_out + OW'(w_fire) - OW'(w_rsp);
  assign w_redir_pc = redirect_pc_i & ~(XLEN'(PC_INC) - XLEN'(1));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= FS_IDLE;
      r_fetch_pc <= RESET_PC;
      r_rsp_pc   <= RESET_PC;
      r_out      <= '0;
      r_drop     <= '0;
    end else begin
      case (r_state)
        FS_IDLE: if (start_i) r_state <= FS_RUN;
        FS_RUN:  if (!start_i) r_state <= FS_STOP;
        FS_STOP: begin
          if (start_i)           r_state <= FS_RUN;
          else if (r_out == '0)  r_state <= FS_IDLE;
        end
        default: r_state <= FS_IDLE;
      endcase

      r_out <= w_out_next;

      if (redirect_i) begin
        // Everything still in flight after this edge is stale and must be
        // discarded; in IDLE this is zero, in STOP it covers leftovers.
        r_fetch_pc <= w_redir_pc;
        r_rsp_pc   <= w_redir_pc;
        r_drop     <= w_out_next;
      end else begin
        if (w_fire) r_fetch_pc <= r_fetch_pc + XLEN'(PC_INC);
        if (w_push) r_rsp_pc   <= r_rsp_pc + XLEN'(PC_INC);
        if (w_drop) r_drop     <= r_drop - OW'(1);
      end
    end
  end

  fetch_fifo #(
    .WIDTH (XLEN + ILEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .data_i  ({r_rsp_pc, imem_rdata_i}),
    .pop_i   (w_pop),
    .flush_i (redirect_i),
    .data_o  (w_head),
    .count_o (w_count)
  );

  assign imem_req_o    = w_req;
  assign imem_addr_o   = r_fetch_pc;
  assign instr_valid_o = (w_count != '0);
  assign instr_pc_o    = w_head[XLEN+ILEN-1:ILEN];
  assign instr_o       = w_head[ILEN-1:0];
  assign busy_o        = (r_out != '0) || (w_count != '0);

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned MAX_OUT = 2;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;
  logic        busy_o;

  fetch_queue #(
    .XLEN     (32),
    .DEPTH    (DEPTH),
    .MAX_OUT  (MAX_OUT),
    .RESET_PC (32'h0)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_ready_i (instr_ready_i),
    .busy_o        (busy_o)
  );

  initial forever #5 clk_i = ~clk_i;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned n_grants = 0;
  int unsigned gnt_pct = 0;
  int unsigned rsp_pct = 0;
  int unsigned spur_pct = 0;

  logic [31:0] delivered[$];
  logic [31:0] grant_log[$];

  typedef struct packed {
    logic [31:0] pc;
    logic        stale;
  } inf_t;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction memory: in-order responder, data is a fixed function of address.
  initial begin
    logic [31:0] mq[$];
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        mq.delete();
      end else begin
        if (imem_rvalid_i && mq.size() > 0) void'(mq.pop_front());
        if (imem_req_o && imem_gnt_i) mq.push_back(imem_addr_o);
      end
      @(posedge clk_i);
      #1;
      imem_gnt_i = ($urandom_range(99) < gnt_pct);
      if (mq.size() > 0 && $urandom_range(99) < rsp_pct) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = mem_word(mq[0]);
      end else if (mq.size() == 0 && $urandom_range(99) < spur_pct) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = $urandom;
      end else begin
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
      end
    end
  end

  // Reference model + monitor: the architectural stream after any redirect is
  // target, target+4, ...; granted fetches are expected in the queue in order.
  initial begin
    inf_t        inflight[$];
    logic [31:0] fq[$];
    logic [31:0] exp_pc;
    logic        prev_start;
    logic        exp_req;
    inf_t        e;
    exp_pc     = 32'h0;
    prev_start = 1'b0;
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        inflight.delete();
        fq.delete();
        exp_pc     = 32'h0;
        prev_start = 1'b0;
      end else begin
        chk("instr_valid", 64'(instr_valid_o), 64'(fq.size() > 0));
        if (fq.size() > 0) begin
          chk("instr_pc", 64'(instr_pc_o), 64'(fq[0]));
          chk("instr", 64'(instr_o), 64'(mem_word(fq[0])));
        end else begin
          chk("head_empty", {instr_pc_o, instr_o}, 64'h0);
        end
        chk("busy", 64'(busy_o), 64'((inflight.size() > 0) || (fq.size() > 0)));
        exp_req = prev_start && start_i && !redirect_i &&
                  (inflight.size() < MAX_OUT) &&
                  (inflight.size() + fq.size() < DEPTH);
        chk("imem_req", 64'(imem_req_o), 64'(exp_req));
        if (imem_req_o) chk("imem_addr", 64'(imem_addr_o), 64'(exp_pc));

        if (instr_valid_o && instr_ready_i) begin
          delivered.push_back(instr_pc_o);
          if (fq.size() > 0) void'(fq.pop_front());
        end
        if (imem_rvalid_i && inflight.size() > 0) begin
          e = inflight.pop_front();
          if (!e.stale && !redirect_i) fq.push_back(e.pc);
        end
        if (redirect_i) begin
          fq.delete();
          foreach (inflight[k]) inflight[k].stale = 1'b1;
          exp_pc = {redirect_pc_i[31:2], 2'b00};
        end else if (imem_req_o && imem_gnt_i) begin
          inflight.push_back('{pc: exp_pc, stale: 1'b0});
          grant_log.push_back(imem_addr_o);
          exp_pc = exp_pc + 32'd4;
          n_grants++;
        end
        prev_start = start_i;
      end
    end
  end

  task automatic cyc(input int unsigned n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic smp();
    @(negedge clk_i);
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect_i    = 1'b1;
    redirect_pc_i = pc;
    cyc(1);
    redirect_i = 1'b0;
    delivered.delete();
    grant_log.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned g0;
    logic        found;
    logic [31:0] a0;

    rst_i = 1'b0; start_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    instr_ready_i = 1'b0;

    // Reset values
    smp(); smp();
    chk("rst_req", 64'(imem_req_o), 64'h0);
    chk("rst_addr", 64'(imem_addr_o), 64'h0);
    chk("rst_valid", 64'(instr_valid_o), 64'h0);
    chk("rst_instr", 64'(instr_o), 64'h0);
    chk("rst_pc", 64'(instr_pc_o), 64'h0);
    chk("rst_busy", 64'(busy_o), 64'h0);

    // Streaming fetch from reset PC
    cyc(1);
    rst_i = 1'b1; gnt_pct = 100; rsp_pct = 100; instr_ready_i = 1'b1;
    start_i = 1'b1;
    cyc(10);
    chk("s1_ndeliv", 64'(delivered.size() >= 3), 64'h1);
    for (int i = 0; i < 3; i++)
      if (i < delivered.size()) chk("s1_pc", 64'(delivered[i]), 64'(4 * i));
    chk("s1_grant0", 64'(grant_log.size() > 0 ? grant_log[0] : 32'hDEAD), 64'h0);

    // Consumer stalled: credits stop requests at DEPTH entries
    instr_ready_i = 1'b0;
    do_redirect(32'h200);
    g0 = n_grants;
    cyc(15);
    smp();
    chk("s2_grants", 64'(n_grants - g0), 64'd4);
    chk("s2_req_off", 64'(imem_req_o), 64'h0);
    chk("s2_valid", 64'(instr_valid_o), 64'h1);
    chk("s2_head_pc", 64'(instr_pc_o), 64'h200);
    cyc(1);
    gnt_pct = 0; instr_ready_i = 1'b1;
    cyc(6);
    chk("s2_ndeliv", 64'(delivered.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      if (i < delivered.size()) chk("s2_pc", 64'(delivered[i]), 64'(32'h200 + 4 * i));

    // Grant withheld: address must hold
    cyc(2);
    smp(); a0 = imem_addr_o;
    chk("s3_req", 64'(imem_req_o), 64'h1);
    chk("s3_addr0", 64'(a0), 64'h210);
    smp(); chk("s3_addr1", 64'(imem_addr_o), 64'h210);
    smp(); chk("s3_addr2", 64'(imem_addr_o), 64'h210);

    // Redirect with two requests in flight
    cyc(1);
    rsp_pct = 0; gnt_pct = 100;
    g0 = n_grants; found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      smp();
      if (n_grants - g0 >= 2) found = 1'b1;
    end
    chk("s4_two_outstanding", 64'(found), 64'h1);
    cyc(1);
    do_redirect(32'h103);
    rsp_pct = 100;
    smp();
    chk("s4_valid_flushed", 64'(instr_valid_o), 64'h0);
    chk("s4_busy", 64'(busy_o), 64'h1);
    cyc(10);
    chk("s4_grant0", 64'(grant_log.size() > 0 ? grant_log[0] : 32'hDEAD), 64'h100);
    chk("s4_deliv0", 64'(delivered.size() > 0 ? delivered[0] : 32'hDEAD), 64'h100);

    // PC wrap-around
    do_redirect(32'hFFFF_FFFC);
    cyc(8);
    chk("s5_grant0", 64'(grant_log.size() > 0 ? grant_log[0] : 32'hDEAD), 64'hFFFF_FFFC);
    chk("s5_grant1", 64'(grant_log.size() > 1 ? grant_log[1] : 32'hDEAD), 64'h0);
    chk("s5_deliv0", 64'(delivered.size() > 0 ? delivered[0] : 32'hDEAD), 64'hFFFF_FFFC);
    chk("s5_deliv1", 64'(delivered.size() > 1 ? delivered[1] : 32'hDEAD), 64'h0);

    // Stop with one request outstanding
    gnt_pct = 0;
    cyc(6);
    smp();
    chk("s6_idle_busy", 64'(busy_o), 64'h0);
    cyc(1);
    instr_ready_i = 1'b0; rsp_pct = 0; gnt_pct = 100;
    g0 = n_grants; found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      smp();
      if (n_grants > g0) found = 1'b1;
    end
    chk("s6_one_grant", 64'(found), 64'h1);
    cyc(1);
    start_i = 1'b0; gnt_pct = 0;
    cyc(2);
    smp();
    chk("s6_busy_out", 64'(busy_o), 64'h1);
    chk("s6_req_off", 64'(imem_req_o), 64'h0);
    cyc(1);
    rsp_pct = 100;
    cyc(4);
    smp();
    chk("s6_queued", 64'(instr_valid_o), 64'h1);
    chk("s6_busy_q", 64'(busy_o), 64'h1);
    cyc(1);
    instr_ready_i = 1'b1;
    cyc(3);
    smp();
    chk("s6_drained_busy", 64'(busy_o), 64'h0);
    chk("s6_drained_valid", 64'(instr_valid_o), 64'h0);

    // Randomized traffic with a mid-run reset
    cyc(1);
    gnt_pct = 60; rsp_pct = 50; spur_pct = 10; start_i = 1'b1;
    delivered.delete(); grant_log.delete();
    for (int i = 0; i < 3000; i++) begin
      cyc(1);
      instr_ready_i = ($urandom_range(99) < 70);
      if (!redirect_i && $urandom_range(99) < 3) begin
        redirect_i    = 1'b1;
        redirect_pc_i = $urandom;
      end else begin
        redirect_i = 1'b0;
      end
      if ($urandom_range(99) < 2) start_i = ~start_i;
      if (i == 1500) rst_i = 1'b0;
      if (i == 1502) begin
        chk("mid_rst_busy", 64'(busy_o), 64'h0);
        chk("mid_rst_valid", 64'(instr_valid_o), 64'h0);
        chk("mid_rst_addr", 64'(imem_addr_o), 64'h0);
      end
      if (i == 1503) rst_i = 1'b1;
      if (i == 2000) delivered.delete();
      if (i == 2000) grant_log.delete();
    end

    // Final drain
    cyc(1);
    start_i = 1'b0; redirect_i = 1'b0; instr_ready_i = 1'b1;
    gnt_pct = 0; rsp_pct = 100; spur_pct = 0;
    cyc(20);
    smp();
    chk("end_busy", 64'(busy_o), 64'h0);
    chk("end_req", 64'(imem_req_o), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
